// File: rtl/scan_test_sequencer.sv
// Scan-test controller: LFSR patterns into the core scan chain, MISR compaction of scan_out, signature compare.
// Capture is a single cycle and unload overlaps the next shift; outputs are registered from the next state.
module scan_test_sequencer #(
  parameter int          CHAIN_LEN    = 64,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected_sig,
  input  logic        scan_out,
  output logic        scan_en,
  output logic        scan_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int BW = $clog2(CHAIN_LEN);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [PW-1:0] pat_cnt, pat_cnt_nxt, pat_inc;
  logic [15:0]   lfsr, lfsr_nxt, lfsr_step;
  logic [15:0]   misr, misr_nxt, misr_step;
  logic [15:0]   signature_nxt;
  logic          pass_nxt, scan_en_nxt, scan_in_nxt, busy_nxt, done_nxt;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign misr_step = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {15'b0, scan_out};
  assign pat_inc   = pat_cnt + PW'(1);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    pat_cnt_nxt   = pat_cnt;
    lfsr_nxt      = lfsr;
    misr_nxt      = misr;
    pass_nxt      = pass;
    signature_nxt = signature;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_nxt      = LFSR_SEED;
          misr_nxt      = 16'h0000;
          pat_cnt_nxt   = '0;
          bit_cnt_nxt   = '0;
          pass_nxt      = 1'b0;
          signature_nxt = 16'h0000;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_nxt = lfsr_step;
        // The first load shifts out power-on garbage, so it is kept out of the signature.
        if (pat_cnt != '0) misr_nxt = misr_step;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = CAPTURE;
        end else begin
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
      CAPTURE: begin
        pat_cnt_nxt = pat_inc;
        state_nxt   = (pat_inc == PAT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        misr_nxt = misr_step;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = COMPARE;
        end else begin
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
      COMPARE: begin
        signature_nxt = misr;
        pass_nxt      = (misr == expected_sig);
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Pin outputs are registered from the next state so they switch on the edge entering it.
    scan_en_nxt = (state_nxt == SHIFT) || (state_nxt == UNLOAD);
    scan_in_nxt = (state_nxt == SHIFT) ? lfsr_nxt[0] : 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      pat_cnt   <= '0;
      lfsr      <= 16'h0000;
      misr      <= 16'h0000;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 16'h0000;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      pat_cnt   <= pat_cnt_nxt;
      lfsr      <= lfsr_nxt;
      misr      <= misr_nxt;
      scan_en   <= scan_en_nxt;
      scan_in   <= scan_in_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      signature <= signature_nxt;
    end
  end

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Bench for scan_test_sequencer: loopback / stuck / random scan_out against a timeline-based reference model.
module tb_scan_test_sequencer;

  localparam int L     = 8;
  localparam int N     = 2;
  localparam int TDONE = (N + 1) * L + N + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, start, scan_out, scan_en, scan_in, busy, done, pass;
  logic [15:0] expected_sig, signature;

  logic [1:0]   mode;
  logic         rnd_bit;
  logic [L-1:0] dly;
  bit           so_log [0:63];
  bit           stream [0:N*L-1];

  int n_cmp = 0;
  int n_bad = 0;

  scan_test_sequencer #(.CHAIN_LEN(L), .NUM_PATTERNS(N), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_sig(expected_sig), .scan_out(scan_out),
    .scan_en(scan_en), .scan_in(scan_in), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  always #5 clk = ~clk;

  // Core model: mode 0 = chain loopback, 1 = stuck-0, 2 = stuck-1, 3 = random.
  always @(posedge clk) dly <= {dly[L-2:0], scan_in};
  assign scan_out = (mode == 2'd0) ? dly[L-1] : (mode == 2'd1) ? 1'b0 :
                    (mode == 2'd2) ? 1'b1 : rnd_bit;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Run timeline: pattern p shifts in cycles p*(L+1)+1 .. p*(L+1)+L, captures at (p+1)*(L+1),
  // then unload fills N*(L+1)+1 .. N*(L+1)+L and COMPARE is cycle TDONE.
  function automatic bit exp_en(input int t);
    if (t > N * (L + 1)) return t <= N * (L + 1) + L;
    return (t >= 1) && (((t - 1) % (L + 1)) != L);
  endfunction

  function automatic bit exp_si(input int t);
    if (t >= 1 && t <= N * (L + 1) && ((t - 1) % (L + 1)) != L)
      return stream[((t - 1) / (L + 1)) * L + (t - 1) % (L + 1)];
    return 1'b0;
  endfunction

  function automatic bit misr_upd(input int t);
    if (t > L + 1 && t <= N * (L + 1)) return ((t - 1) % (L + 1)) != L;
    return (t > N * (L + 1)) && (t <= N * (L + 1) + L);
  endfunction

  function automatic logic [15:0] model_sig(input int md);
    logic [15:0] m = 16'h0000;
    bit b;
    for (int t = 1; t < TDONE; t++) begin
      if (misr_upd(t)) begin
        if (md == 0)      b = (t > L) ? exp_si(t - L) : 1'b0;
        else if (md == 1) b = 1'b0;
        else if (md == 2) b = 1'b1;
        else              b = so_log[t];
        m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
      end
    end
    return m;
  endfunction

  // Entered in an IDLE cycle; that cycle is cycle 0 with start asserted.
  task automatic run(input int md, input logic [15:0] esig, input int spulse, input bit hold,
                     output logic [15:0] sig_out);
    logic [15:0] ms;
    mode = md[1:0];
    expected_sig = esig;
    start = 1'b1;
    for (int t = 1; t <= TDONE + 1; t++) begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
      if (hold)             start = 1'b1;
      else if (spulse == 1) start = (t == 3) || (t == 15);
      else if (spulse == 2) start = (t <= TDONE) && ($urandom_range(0, 3) == 0);
      else                  start = 1'b0;
      #1;
      so_log[t] = scan_out;
      if (t == 1) begin
        chk("pass_clear", t, 32'(pass), 32'd0);
        chk("sig_clear", t, 32'(signature), 32'd0);
      end
      chk("scan_en", t, 32'(scan_en), 32'(exp_en(t)));
      chk("scan_in", t, 32'(scan_in), 32'(exp_si(t)));
      chk("busy", t, 32'(busy), 32'(t <= TDONE));
      chk("done", t, 32'(done), 32'(t == TDONE));
      if (t == TDONE + 1) begin
        ms = model_sig(md);
        chk("signature", t, 32'(signature), 32'(ms));
        chk("pass", t, 32'(pass), 32'(ms == esig));
      end
    end
    sig_out = signature;
  endtask

  initial begin
    logic [15:0] l, s1, s2, ref_sig;
    l = SEED;
    for (int i = 0; i < N * L; i++) begin
      stream[i] = l[0];
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    dly = '0;
    mode = 2'd0;
    rnd_bit = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    expected_sig = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scan_en", 0, 32'(scan_en), 32'd0);
    chk("rst_scan_in", 0, 32'(scan_in), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk("rst_pass", 0, 32'(pass), 32'd0);
    chk("rst_signature", 0, 32'(signature), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loopback with matching and mismatching golden signature.
    ref_sig = model_sig(0);
    run(0, ref_sig, 0, 1'b0, s1);
    chk("loop_sig_eq_golden", 0, 32'(s1), 32'(ref_sig));
    run(0, ref_sig ^ 16'h0001, 0, 1'b0, s1);

    // Stuck-at scan_out.
    run(1, 16'h0000, 0, 1'b0, s1);
    chk("stuck0_pass", 0, 32'(pass), 32'd1);
    run(2, 16'h0000, 0, 1'b0, s1);
    chk("stuck1_sig_nonzero", 0, 32'(s1 != 16'h0000), 32'd1);

    // Reset in the middle of the first shift.
    mode = 2'd0;
    start = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_scan_en", 6, 32'(scan_en), 32'd0);
    chk("mid_rst_busy", 6, 32'(busy), 32'd0);
    chk("mid_rst_done", 6, 32'(done), 32'd0);
    chk("mid_rst_signature", 6, 32'(signature), 32'd0);
    rst = 1'b0;
    run(0, ref_sig, 0, 1'b0, s1);

    // Start pulses while busy are ignored.
    run(0, ref_sig, 1, 1'b0, s1);

    // Start held through done: back-to-back runs.
    run(0, ref_sig, 0, 1'b1, s1);
    run(0, ref_sig, 0, 1'b0, s2);
    chk("b2b_sig_equal", 0, 32'(s2), 32'(s1));

    // Random scan_out with random start noise during the run.
    for (int k = 0; k < 4; k++) run(3, 16'($urandom), 2, 1'b0, s1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
